cast_credit_scheduler: RTL and testbench
========================================

# cast_credit_scheduler

Sender-side flow controller for the cast network. It sits between a caster's `cast_converter` output and the cast router port. It holds a per-destination credit count for every multicast receiver: each receiver's cast receive FIFO returns one `credit_upd` pulse per flit it drains. A flit is injected only when every enabled destination has buffer space, so a receiver FIFO can never overflow. It also sequences safe reconfiguration of the destination set: block new input, drain, reload credits, resume.

## Interface

Parameters:
- `NUM_DST`, default 4: number of multicast destinations tracked.
- `CREDIT_MAX`, default `` `BUFFER_ALLOC ``: initial and maximum credits per destination, equal to the receiver FIFO depth.
- `CW`, default `$clog2(CREDIT_MAX+1)`: credit counter width.

Ports:
- Clocking and reset (already decided): one clock; reset is asynchronous and active-low.
  - `clk`  in  1  clock.
  - `rstn`  in  1  asynchronous active-low reset.
- Configuration:
  - `dst_mask_i`  in  NUM_DST  enabled destinations; sampled only in INIT.
  - `cfg_load_i`  in  1  one-cycle pulse requesting reconfiguration.
- Upstream input:
  - `valid_i`  in  1  flit valid.
  - `data_i`  in  `` `DW ``  flit data.
  - `ready_o`  out  1  flit accepted when high together with `valid_i`.
- Downstream output:
  - `valid_o`  out  1  flit valid toward the cast router.
  - `data_o`  out  `` `DW ``  flit data.
  - `ready_i`  in  1  router ready.
- Credit and status:
  - `credit_upd_i`  in  NUM_DST  one pulse per flit drained at destination *i*.
  - `busy_o`  out  1  high in any state other than RUN.
  - `overflow_o`  out  1  sticky flag: a credit return arrived at a destination whose counter is already full.

## Operation

- State machine:
  - Reset enters INIT.
  - INIT lasts 1 cycle and then goes to RUN.
  - In RUN, a `cfg_load_i` pulse goes to DRAIN.
  - DRAIN goes to INIT when the output register is empty and every masked counter equals CREDIT_MAX.
  - `cfg_load_i` is ignored outside RUN.
- INIT actions:
  - Latch `dst_mask_i` into `mask_q`.
  - Load all counters to CREDIT_MAX.
  - Keep `overflow_o` unchanged.
- Output stage is a one-entry register (`valid_o`, `data_o`):
  - `out_free = ~valid_o | ready_i`.
- Accept condition:
  - `ready_o = (state==RUN) & out_free & all_ok`.
  - `all_ok = &(~mask_q | (cnt != 0))`.
  - An accept (`valid_i & ready_o`) loads the register.
  - A downstream fire without a new accept clears `valid_o`.
- Counter update for each destination *i*:
  - `dec = accept & mask_q[i]`; `inc = credit_upd_i[i] & mask_q[i]`.
  - Next value is `cnt - dec + inc`, so simultaneous dec and inc hold the count.
  - If `inc` arrives with no `dec` while `cnt == CREDIT_MAX`, the counter holds and `overflow_o` sets.
  - Unmasked counters hold CREDIT_MAX, and their `credit_upd_i` bits are ignored.
- An empty mask (`mask_q == 0`) means `all_ok` is 1 and flits pass with no credit accounting.
- `overflow_o` clears only on reset.

## Timing

- Reset values:
  - `ready_o=0`, `valid_o=0`, `data_o=0`, `busy_o=1`, `overflow_o=0`.
  - Counters are CREDIT_MAX, `mask_q` is 0, state is INIT.
- First accept is possible in the 2nd cycle after `rstn` deasserts (INIT, then RUN).
- Latency is 1 cycle from input accept to `valid_o`.
- Full throughput: 1 flit/cycle while credits are available and `ready_i=1`.
- A credit consumed at cycle *t* makes `ready_o` low at *t+1* if the count hits 0.
- A credit returned at cycle *t* can enable `ready_o` at *t+1*, never the same cycle.
- `ready_o` is not combinationally dependent on `valid_i`.
- `valid_o` and `data_o` stay stable while `valid_o & ~ready_i`.
- A `cfg_load_i` in the same cycle as an accept: the accept completes, and DRAIN starts next cycle.
- Asynchronous reset mid-flit drops any registered flit and restores the reset values above.

## Structure

- Shared package `cast_ctrl_pkg`:
  - State typedef `cast_sched_state_t` with values INIT, RUN, DRAIN.
- `` `DW `` and `` `BUFFER_ALLOC `` come from `params.svh`.
- Sub-module `credit_counter`, instantiated NUM_DST times with a generate loop:
  - Inputs: `load`, `dec`, `inc`.
  - Outputs: `cnt`, `nonzero`, `full`, `ovf`.

## Test plan

Configuration for all cases: NUM_DST=4, CREDIT_MAX=4, `dst_mask_i=4'b0101`.

- Reset then stream 10 flits with `ready_i=1` and no credits returned: exactly 4 flits accepted, then `ready_o=0`; counters 0 and 2 read 0, counters 1 and 3 read 4.
- From the stalled state, pulse `credit_upd_i[0]` only: still blocked. Then pulse `credit_upd_i[2]`: `ready_o=1` on the next cycle, and exactly 1 more flit is accepted.
- Hold `ready_i=0` with `valid_o` high for 5 cycles: `data_o` is unchanged, `ready_o=0`, and the flit is delivered once `ready_i` rises.
- Credit return on destination 0 in the same cycle as an accept: counter 0 is unchanged. An extra `credit_upd_i[0]` at count 4 sets `overflow_o=1` and keeps the count at 4.
- `cfg_load_i` with 2 flits outstanding and new mask `4'b0011`: `busy_o=1` and `ready_o=0` until 2 credits return on destinations 0 and 2, then 1 INIT cycle, then RUN with mask 0011.
- Pulse `credit_upd_i[1]` while its mask bit is 0: no overflow, and counter 1 stays at 4.

Source files
------------

// File: rtl/cast_ctrl_pkg.sv
// cast_ctrl_pkg: shared types for the cast network control blocks.
package cast_ctrl_pkg;
  typedef enum logic [1:0] {INIT = 2'd0, RUN = 2'd1, DRAIN = 2'd2} cast_sched_state_t;
endpackage

// File: rtl/credit_counter.sv
// credit_counter: one destination's credit count, saturating at CREDIT_MAX with overflow report.
module credit_counter #(
  parameter int CREDIT_MAX = 4,
  parameter int CW         = $clog2(CREDIT_MAX + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          load,
  input  logic          dec,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          nonzero,
  output logic          full,
  output logic          ovf
);
  localparam logic [CW-1:0] MAX = CW'(CREDIT_MAX);
  logic [CW-1:0] cnt_q, cnt_d;
  assign cnt     = cnt_q;
  assign nonzero = cnt_q != '0;
  assign full    = cnt_q == MAX;
  // a lone return into a full counter is a protocol error: hold and report
  assign ovf     = ~load & inc & ~dec & full;
  always_comb cnt_d = load ? MAX : ovf ? cnt_q : cnt_q - CW'(dec) + CW'(inc);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) cnt_q <= MAX;
    else       cnt_q <= cnt_d;
endmodule

// File: rtl/params.svh
`ifndef PARAMS_SVH
`define PARAMS_SVH
`define DW 32
`define BUFFER_ALLOC 4
`endif

// File: rtl/cast_credit_scheduler.sv
// cast_credit_scheduler: credit-gated one-entry injection stage with drain/reload reconfiguration.
`include "params.svh"
module cast_credit_scheduler
  import cast_ctrl_pkg::*;
#(
  parameter int NUM_DST    = 4,
  parameter int CREDIT_MAX = `BUFFER_ALLOC,
  parameter int CW         = $clog2(CREDIT_MAX + 1)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NUM_DST-1:0] dst_mask_i,
  input  logic               cfg_load_i,
  input  logic               valid_i,
  input  logic [`DW-1:0]     data_i,
  output logic               ready_o,
  output logic               valid_o,
  output logic [`DW-1:0]     data_o,
  input  logic               ready_i,
  input  logic [NUM_DST-1:0] credit_upd_i,
  output logic               busy_o,
  output logic               overflow_o
);
  cast_sched_state_t  state_q, state_d;
  logic [NUM_DST-1:0] mask_q, nz, full, ovf;
  logic [CW-1:0]      cnt [NUM_DST];
  logic               valid_q, ovf_q, load, accept, all_ok, all_full;
  logic [`DW-1:0]     data_q;

  assign load     = state_q == INIT;
  assign all_ok   = &(~mask_q | nz);
  assign all_full = &(~mask_q | full);
  assign ready_o  = (state_q == RUN) & (~valid_q | ready_i) & all_ok;
  assign accept   = valid_i & ready_o;
  assign valid_o  = valid_q;
  assign data_o   = data_q;
  assign busy_o   = state_q != RUN;
  assign overflow_o = ovf_q;

  for (genvar g = 0; g < NUM_DST; g++) begin : g_cnt
    credit_counter #(.CREDIT_MAX(CREDIT_MAX), .CW(CW)) u_cnt (
      .clk(clk), .rstn(rstn), .load(load),
      .dec(accept & mask_q[g]), .inc(credit_upd_i[g] & mask_q[g]),
      .cnt(cnt[g]), .nonzero(nz[g]), .full(full[g]), .ovf(ovf[g])
    );
    a_cnt_range: assert property (@(posedge clk) disable iff (!rstn) cnt[g] <= CW'(CREDIT_MAX));
  end

  always_comb
    state_d = (state_q == INIT) ? RUN :
              (state_q == RUN && cfg_load_i) ? DRAIN :
              (state_q == DRAIN && !valid_q && all_full) ? INIT : state_q;

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state_q <= INIT;
      mask_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) mask_q <= dst_mask_i;
      valid_q <= accept | (valid_q & ~ready_i);
      if (accept) data_q <= data_i;
      ovf_q   <= ovf_q | (|ovf);
    end
endmodule

// File: tb/tb_cast_credit_scheduler.sv
// tb_cast_credit_scheduler: directed plan plus random traffic against a behavioural model.
module tb_cast_credit_scheduler;
  localparam int N = 4, MAX = 4;
  logic        clk = 0, rstn = 0;
  logic [3:0]  dst_mask_i = 4'b0101, credit_upd_i = 0;
  logic        cfg_load_i = 0, valid_i = 0, ready_i = 0;
  logic [31:0] data_i = 0, data_o;
  logic        ready_o, valid_o, busy_o, overflow_o;
  logic [2:0]  dc [N];

  cast_credit_scheduler #(.NUM_DST(N), .CREDIT_MAX(MAX)) dut (
    .clk(clk), .rstn(rstn), .dst_mask_i(dst_mask_i), .cfg_load_i(cfg_load_i),
    .valid_i(valid_i), .data_i(data_i), .ready_o(ready_o), .valid_o(valid_o),
    .data_o(data_o), .ready_i(ready_i), .credit_upd_i(credit_upd_i),
    .busy_o(busy_o), .overflow_o(overflow_o)
  );
  assign dc[0] = dut.cnt[0];
  assign dc[1] = dut.cnt[1];
  assign dc[2] = dut.cnt[2];
  assign dc[3] = dut.cnt[3];

  always #5 clk = ~clk;

  // model: phase 0=init 1=run 2=drain, per-destination credits, one-slot output
  int          ms, mc [N], n_cmp = 0, n_bad = 0, n_acc = 0;
  logic [3:0]  mm;
  logic        mv, movf, want_rst = 1;
  logic [31:0] md, saved;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  task automatic mreset();
    ms = 0; mm = 0; mv = 0; md = 0; movf = 0;
    for (int i = 0; i < N; i++) mc[i] = MAX;
  endtask

  function automatic logic m_rdy();
    logic ok = 1;
    for (int i = 0; i < N; i++) if (mm[i] && mc[i] == 0) ok = 0;
    return ms == 1 && (!mv || ready_i) && ok;
  endfunction

  task automatic step(input logic v, input logic [31:0] d, input logic r,
                      input logic [3:0] cr, input logic cfg, input logic [3:0] msk);
    int nc [N];
    int nms;
    logic [3:0] nmm;
    logic nmv, novf, acc, fullall;
    logic [31:0] nmd;
    @(negedge clk);
    valid_i = v; data_i = d; ready_i = r; credit_upd_i = cr; cfg_load_i = cfg; dst_mask_i = msk;
    rstn = ~want_rst;
    if (want_rst) mreset();
    #1;
    chk("ready_o", ready_o, m_rdy());
    chk("valid_o", valid_o, mv);
    chk("data_o", data_o, md);
    chk("busy_o", busy_o, ms != 1);
    chk("overflow_o", overflow_o, movf);
    for (int i = 0; i < N; i++) chk($sformatf("cnt%0d", i), dc[i], mc[i]);
    acc = v && m_rdy();
    if (acc) n_acc++;
    fullall = 1;
    for (int i = 0; i < N; i++) if (mm[i] && mc[i] != MAX) fullall = 0;
    novf = movf;
    for (int i = 0; i < N; i++) begin
      int dd, ii;
      dd = (acc && mm[i]) ? 1 : 0;
      ii = (cr[i] && mm[i]) ? 1 : 0;
      if (ms == 0) nc[i] = MAX;
      else if (ii == 1 && dd == 0 && mc[i] == MAX) begin nc[i] = mc[i]; novf = 1; end
      else nc[i] = mc[i] - dd + ii;
    end
    nmv = acc ? 1'b1 : (mv && !r) ? 1'b1 : 1'b0;
    nmd = acc ? d : md;
    nmm = (ms == 0) ? msk : mm;
    nms = (ms == 0) ? 1 : (ms == 1 && cfg) ? 2 : (ms == 2 && !mv && fullall) ? 0 : ms;
    @(posedge clk);
    if (!want_rst) begin
      ms = nms; mm = nmm; mv = nmv; md = nmd; movf = novf;
      for (int i = 0; i < N; i++) mc[i] = nc[i];
    end
    #1;
  endtask

  initial begin
    mreset();
    repeat (3) step(0, 0, 0, 0, 0, 4'b0101);
    want_rst = 0;
    // credit pulse on an unmasked destination is ignored
    step(0, 0, 1, 4'b0010, 0, 4'b0101);
    step(0, 0, 1, 4'b0010, 0, 4'b0101);
    chk("unmasked_no_ovf", overflow_o, 0);
    chk("unmasked_cnt1", dc[1], 4);
    n_acc = 0;
    for (int k = 0; k < 10; k++) step(1, 32'h100 + k, 1, 0, 0, 4'b0101);
    chk("stream_accepts", n_acc, 4);
    chk("stall_ready", ready_o, 0);
    chk("stall_cnt0", dc[0], 0);
    chk("stall_cnt2", dc[2], 0);
    chk("stall_cnt3", dc[3], 4);
    step(0, 0, 1, 4'b0001, 0, 4'b0101);
    chk("one_credit_blocked", ready_o, 0);
    step(0, 0, 1, 4'b0100, 0, 4'b0101);
    chk("both_credits_ready", ready_o, 1);
    n_acc = 0;
    for (int k = 0; k < 3; k++) step(1, 32'h200 + k, 1, 0, 0, 4'b0101);
    chk("one_more_accept", n_acc, 1);
    step(0, 0, 1, 4'b0101, 0, 4'b0101);
    step(1, 32'hCAFE_F00D, 0, 0, 0, 4'b0101);
    saved = 32'hCAFE_F00D;
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 0, 0, 0, 4'b0101);
      chk("hold_data", data_o, saved);
      chk("hold_ready", ready_o, 0);
    end
    step(0, 0, 1, 0, 0, 4'b0101);
    chk("delivered", valid_o, 0);
    step(0, 0, 1, 4'b0101, 0, 4'b0101);
    step(1, 32'h300, 1, 4'b0001, 0, 4'b0101);
    chk("same_cycle_cnt0", dc[0], 1);
    repeat (3) step(0, 0, 1, 4'b0101, 0, 4'b0101);
    step(0, 0, 1, 4'b0100, 0, 4'b0101);
    step(0, 0, 1, 4'b0001, 0, 4'b0101);
    chk("ovf_set", overflow_o, 1);
    chk("ovf_cnt0", dc[0], 4);
    step(1, 32'h400, 1, 0, 0, 4'b0101);
    step(1, 32'h401, 1, 0, 0, 4'b0101);
    step(0, 0, 1, 0, 1, 4'b0011);
    chk("drain_busy", busy_o, 1);
    chk("drain_ready", ready_o, 0);
    step(0, 0, 1, 4'b0101, 0, 4'b0011);
    chk("drain_still_busy", busy_o, 1);
    step(0, 0, 1, 4'b0101, 0, 4'b0011);
    step(0, 0, 1, 0, 0, 4'b0011);
    chk("init_busy", busy_o, 1);
    step(0, 0, 1, 0, 0, 4'b0011);
    chk("resumed", busy_o, 0);
    chk("new_mask", mm, 4'b0011);
    for (int k = 0; k < 2000; k++) begin
      want_rst = (k == 1000 || k == 1001);
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) != 0,
           4'($urandom & $urandom & $urandom), $urandom_range(0, 49) == 0, 4'($urandom));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
